// File: rtl/if_trace_buffer.sv
// Elastic first-word-fall-through FIFO between the IF tracker and the trace consumer.
// Push-side never stalls; pushes into a full buffer are dropped, counted and flagged.

package ryuki_datatypes;
  // Completed IF trace record as produced by the IF tracker
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [7:0]  tag;
  } trace_output;
endpackage

module if_trace_buffer
  import ryuki_datatypes::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DROP_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_data_valid,
  input  trace_output             if_data_i,
  input  logic                    flush,
  input  logic                    trace_ready,
  output logic                    trace_valid,
  output trace_output             trace_data_o,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  high_water,
  output logic                    overflow,
  output logic [DROP_WIDTH-1:0]   drop_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  trace_output      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             do_drop;
  logic [CNT_W-1:0] count_nxt;

  assign full         = (count == CNT_W'(DEPTH));
  assign trace_valid  = (count != '0);
  assign trace_data_o = trace_valid ? mem[rd_ptr] : '0;

  // Handshake decode; flush masks both sides, a pop frees room for a same-cycle push
  always_comb begin
    do_pop    = 1'b0;
    do_push   = 1'b0;
    do_drop   = 1'b0;
    count_nxt = count;
    if (!flush) begin
      do_pop  = trace_valid && trace_ready;
      do_push = if_data_valid && (!full || do_pop);
      do_drop = if_data_valid && full && !do_pop;
    end
    if (flush) begin
      count_nxt = '0;
    end else if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Record storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= if_data_i;
    end
  end

  // Pointers, occupancy and high-water tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      high_water <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      high_water <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      if (count_nxt > high_water) high_water <= count_nxt;
    end
  end

  // Sticky overflow flag and saturating drop counter; only reset clears them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (do_drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_if_trace_buffer.sv
// Bench for if_trace_buffer: directed scenarios plus random traffic against a queue model.

module tb_if_trace_buffer;
  import ryuki_datatypes::*;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned DROP_WIDTH = 16;
  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  if_data_valid = 1'b0;
  trace_output           if_data_i = '0;
  logic                  flush = 1'b0;
  logic                  trace_ready = 1'b0;
  logic                  trace_valid;
  trace_output           trace_data_o;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      high_water;
  logic                  overflow;
  logic [DROP_WIDTH-1:0] drop_count;

  if_trace_buffer #(.DEPTH(DEPTH), .DROP_WIDTH(DROP_WIDTH)) dut (
    .clk(clk), .rst(rst), .if_data_valid(if_data_valid), .if_data_i(if_data_i),
    .flush(flush), .trace_ready(trace_ready), .trace_valid(trace_valid),
    .trace_data_o(trace_data_o), .count(count), .high_water(high_water),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of stored records plus scalar statistics
  trace_output m_q[$];
  int          m_hw;
  bit          m_ovf;
  int          m_drops;

  int passed = 0;
  int total  = 0;

  function automatic trace_output rnd_rec();
    return trace_output'({$urandom, $urandom, 8'($urandom)});
  endfunction

  function automatic trace_output m_head();
    if (m_q.size() != 0) return m_q[0];
    return '0;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_hw = 0;
    m_ovf = 1'b0;
    m_drops = 0;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle after it
  task automatic step(input bit push, input trace_output d, input bit rdy, input bit fl);
    @(negedge clk);
    if_data_valid = push;
    if_data_i     = d;
    trace_ready   = rdy;
    flush         = fl;
    @(posedge clk);
    if (fl) begin
      m_q.delete();
      m_hw = 0;
    end else begin
      if (rdy && m_q.size() != 0) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else begin
          m_ovf = 1'b1;
          if (m_drops < (2**DROP_WIDTH) - 1) m_drops++;
        end
      end
      if (m_q.size() > m_hw) m_hw = m_q.size();
    end
    #1;
    if_data_valid = 1'b0;
    trace_ready   = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (count !== '0 || trace_valid !== 1'b0 || trace_data_o !== '0 || high_water !== '0 ||
        overflow !== 1'b0 || drop_count !== '0)
      $display("FAIL reset_state: count=%0d valid=%b hw=%0d ovf=%b drops=%0d required all zero",
               count, trace_valid, high_water, overflow, drop_count);
    else passed++;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_push_three(output trace_output a, output trace_output b, output trace_output c);
    a = rnd_rec(); b = rnd_rec(); c = rnd_rec();
    step(1, a, 0, 0);
    step(1, b, 0, 0);
    step(1, c, 0, 0);
    total++;
    if (count !== CNT_W'(3) || trace_data_o !== a || high_water !== CNT_W'(3) || trace_valid !== 1'b1)
      $display("FAIL push_three: count=%0d hw=%0d valid=%b data=%h required count=3 hw=3 valid=1 data=%h",
               count, high_water, trace_valid, trace_data_o, a);
    else passed++;
  endtask

  task automatic test_drain_order(input trace_output a, input trace_output b, input trace_output c);
    trace_output exp [3];
    exp[0] = a; exp[1] = b; exp[2] = c;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (trace_data_o !== exp[i] || trace_data_o !== m_head())
        $display("FAIL drain_order[%0d]: data=%h required %h", i, trace_data_o, exp[i]);
      else passed++;
      step(0, '0, 1, 0);
    end
    total++;
    if (trace_valid !== 1'b0 || trace_data_o !== '0 || count !== '0)
      $display("FAIL drain_empty: valid=%b count=%0d data=%h required valid=0 count=0 data=0",
               trace_valid, count, trace_data_o);
    else passed++;
    // ready with nothing stored must not disturb anything
    step(0, '0, 1, 0);
    total++;
    if (trace_valid !== 1'b0 || count !== '0)
      $display("FAIL ready_when_empty: valid=%b count=%0d required valid=0 count=0", trace_valid, count);
    else passed++;
  endtask

  task automatic test_overflow();
    trace_output x;
    for (int i = 0; i < DEPTH; i++) step(1, rnd_rec(), 0, 0);
    total++;
    if (count !== CNT_W'(DEPTH) || overflow !== 1'b0)
      $display("FAIL fill_full: count=%0d ovf=%b required count=%0d ovf=0", count, overflow, DEPTH);
    else passed++;
    x = rnd_rec();
    step(1, x, 0, 0);
    total++;
    if (count !== CNT_W'(DEPTH) || overflow !== 1'b1 || drop_count !== DROP_WIDTH'(1) ||
        trace_data_o !== m_head() || high_water !== CNT_W'(DEPTH))
      $display("FAIL overflow_drop: count=%0d ovf=%b drops=%0d hw=%0d required count=8 ovf=1 drops=1 hw=8",
               count, overflow, drop_count, high_water);
    else passed++;
  endtask

  task automatic test_full_push_pop();
    trace_output y;
    y = rnd_rec();
    step(1, y, 1, 0);
    total++;
    if (count !== CNT_W'(DEPTH) || drop_count !== DROP_WIDTH'(m_drops) || drop_count !== DROP_WIDTH'(1))
      $display("FAIL full_push_pop: count=%0d drops=%0d required count=8 drops=1", count, drop_count);
    else passed++;
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (trace_data_o !== m_head() || (i == DEPTH - 1 && trace_data_o !== y))
        $display("FAIL full_drain[%0d]: data=%h required %h", i, trace_data_o, m_head());
      else passed++;
      step(0, '0, 1, 0);
    end
    total++;
    if (trace_valid !== 1'b0)
      $display("FAIL full_drain_empty: valid=%b required 0", trace_valid);
    else passed++;
  endtask

  task automatic test_wrap();
    bit ok_seq = 1'b1;
    bit ok_cnt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (trace_data_o !== m_head()) ok_seq = 1'b0;
      step(1, rnd_rec(), 1, 0);
      if (count > CNT_W'(1) || count !== CNT_W'(m_q.size())) ok_cnt = 1'b0;
    end
    total++;
    if (!ok_seq) $display("FAIL wrap_sequence: order broken=%b required 0", !ok_seq);
    else passed++;
    total++;
    if (!ok_cnt) $display("FAIL wrap_count: count=%0d required <=1", count);
    else passed++;
    step(0, '0, 1, 0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) step(1, rnd_rec(), 0, 0);
    step(1, rnd_rec(), 1, 1);
    total++;
    if (count !== '0 || trace_valid !== 1'b0 || high_water !== '0 ||
        overflow !== 1'(m_ovf) || drop_count !== DROP_WIDTH'(m_drops) || drop_count === '0)
      $display("FAIL flush: count=%0d valid=%b hw=%0d ovf=%b drops=%0d required 0/0/0/%b/%0d",
               count, trace_valid, high_water, overflow, drop_count, m_ovf, m_drops);
    else passed++;
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 5; i++) step(1, rnd_rec(), 0, 0);
    total++;
    if (count !== CNT_W'(5))
      $display("FAIL pre_reset_count: count=%0d required 5", count);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    total++;
    if (count !== '0 || trace_valid !== 1'b0 || trace_data_o !== '0 || drop_count !== '0 || overflow !== 1'b0)
      $display("FAIL async_reset: count=%0d valid=%b drops=%0d ovf=%b required all zero",
               count, trace_valid, drop_count, overflow);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    step(1, rnd_rec(), 0, 1);
    total++;
    if (count !== '0 || drop_count !== '0 || trace_valid !== 1'b0)
      $display("FAIL push_with_flush: count=%0d drops=%0d valid=%b required 0/0/0",
               count, drop_count, trace_valid);
    else passed++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), rnd_rec(), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 60) == 0));
      total++;
      if (count !== CNT_W'(m_q.size()) || trace_valid !== (m_q.size() != 0) ||
          trace_data_o !== m_head() || high_water !== CNT_W'(m_hw) ||
          overflow !== 1'(m_ovf) || drop_count !== DROP_WIDTH'(m_drops)) begin
        if (errs < 10)
          $display("FAIL random[%0d]: count=%0d hw=%0d ovf=%b drops=%0d data=%h required %0d/%0d/%b/%0d/%h",
                   i, count, high_water, overflow, drop_count, trace_data_o,
                   m_q.size(), m_hw, m_ovf, m_drops, m_head());
        errs++;
      end else passed++;
    end
  endtask

  initial begin
    trace_output a, b, c;
    test_reset();
    test_push_three(a, b, c);
    test_drain_order(a, b, c);
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_flush();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
